// File: rtl/vpu_line_sched_if.sv
// CPU-side and VPU-side register bus bundle for vpu_line_sched.
// slave is the scheduler's view; master is the view of the CPU/VPU pair around it.
interface vpu_line_sched_if;
  logic       cpu_cs;
  logic       cpu_rw;
  logic [4:0] cpu_ad;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       cpu_wait;
  logic       vpu_cs;
  logic       vpu_rw;
  logic [3:0] vpu_ad;
  logic [7:0] vpu_do;
  logic [7:0] vpu_di;
  logic       vpu_hold;

  modport slave (
    input  cpu_cs, cpu_rw, cpu_ad, cpu_di, vpu_di, vpu_hold,
    output cpu_do, cpu_wait, vpu_cs, vpu_rw, vpu_ad, vpu_do
  );

  modport master (
    output cpu_cs, cpu_rw, cpu_ad, cpu_di, vpu_di, vpu_hold,
    input  cpu_do, cpu_wait, vpu_cs, vpu_rw, vpu_ad, vpu_do
  );
endinterface

// File: rtl/vpu_line_sched.sv
// Per-scanline VPU DMA scheduler: on each hsync it programs pointer, address, step and
// length into the VPU, waits out the DMA, advances the line address, and arbitrates CPU access.
module vpu_line_sched #(
  parameter int unsigned HOLD_TIMEOUT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsync,
  input  logic              vbl,
  vpu_line_sched_if.slave   bus,
  output logic              busy
);

  localparam int unsigned CW   = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int unsigned LAST = (HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0;

  typedef enum logic [3:0] {
    IDLE, W_PTRH, W_PTRL, W_ADRH, W_ADRL, W_STEP, W_LEN, WAIT_RISE, WAIT_FALL, ADV
  } state_t;

  state_t        state;
  logic          pending;
  logic          wr_act;
  logic [3:0]    wr_ad;
  logic [7:0]    wr_data;
  logic [CW-1:0] wait_cnt;

  logic [7:0]    baseh, basel, stride, len;
  logic          en;
  logic [15:0]   line_addr;
  logic          hs_q, vb_q;

  logic          hs_rise, vb_rise, loc_wr, pt_req, grant;
  logic [7:0]    loc_rd;

  assign hs_rise = hsync & ~hs_q;
  assign vb_rise = vbl & ~vb_q;
  assign loc_wr  = bus.cpu_cs & bus.cpu_ad[4] & ~bus.cpu_rw;
  assign pt_req  = bus.cpu_cs & ~bus.cpu_ad[4];
  assign grant   = (state == IDLE) & ~pending & ~bus.vpu_hold;
  assign busy    = (state != IDLE) | pending;

  // Local registers, sync-edge flops and the line address pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baseh     <= '0;
      basel     <= '0;
      stride    <= 8'h28;
      len       <= 8'h28;
      en        <= 1'b0;
      hs_q      <= 1'b0;
      vb_q      <= 1'b0;
      line_addr <= '0;
    end else begin
      hs_q <= hsync;
      vb_q <= vbl;
      if (loc_wr) begin
        case (bus.cpu_ad[2:0])
          3'd0:    baseh  <= bus.cpu_di;
          3'd1:    basel  <= bus.cpu_di;
          3'd2:    stride <= bus.cpu_di;
          3'd3:    len    <= bus.cpu_di;
          3'd4:    en     <= bus.cpu_di[0];
          default: ;
        endcase
      end
      // A frame reload takes priority over the per-line advance
      if (vb_rise)
        line_addr <= {baseh, basel};
      else if (state == ADV)
        line_addr <= line_addr + {8'h00, stride};
    end
  end

  // Sequencer; wr_act/wr_ad are registered alongside the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= 1'b0;
      wr_act   <= 1'b0;
      wr_ad    <= '0;
      wait_cnt <= '0;
    end else begin
      if (hs_rise && en && !vbl && state == IDLE && !pending)
        pending <= 1'b1;
      case (state)
        IDLE: begin
          if (pending) begin
            pending <= 1'b0;
            state   <= W_PTRH;
            wr_act  <= 1'b1;
            wr_ad   <= 4'h0;
          end
        end
        W_PTRH: begin
          state <= W_PTRL;
          wr_ad <= 4'h1;
        end
        W_PTRL: begin
          state <= W_ADRH;
          wr_ad <= 4'hC;
        end
        W_ADRH: begin
          state <= W_ADRL;
          wr_ad <= 4'hD;
        end
        W_ADRL: begin
          state <= W_STEP;
          wr_ad <= 4'hE;
        end
        W_STEP: begin
          state <= W_LEN;
          wr_ad <= 4'hF;
        end
        W_LEN: begin
          wr_act   <= 1'b0;
          wr_ad    <= '0;
          wait_cnt <= '0;
          state    <= (len != '0) ? WAIT_RISE : ADV;
        end
        WAIT_RISE: begin
          if (bus.vpu_hold)
            state <= WAIT_FALL;
          else if (wait_cnt == LAST[CW-1:0])
            state <= ADV;
          else
            wait_cnt <= wait_cnt + 1'b1;
        end
        WAIT_FALL: begin
          if (!bus.vpu_hold)
            state <= ADV;
        end
        ADV:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Data is picked from the live registers so late STRIDE/LEN writes are honoured
  always_comb begin
    wr_data = '0;
    case (wr_ad)
      4'hC:    wr_data = line_addr[15:8];
      4'hD:    wr_data = line_addr[7:0];
      4'hE:    wr_data = 8'h01;
      4'hF:    wr_data = len;
      default: wr_data = '0;
    endcase
  end

  always_comb begin
    loc_rd = '0;
    case (bus.cpu_ad[2:0])
      3'd0:    loc_rd = baseh;
      3'd1:    loc_rd = basel;
      3'd2:    loc_rd = stride;
      3'd3:    loc_rd = len;
      3'd4:    loc_rd = {busy, 6'b000000, en};
      default: loc_rd = '0;
    endcase
  end

  // VPU select follows only passthrough requests, so local-register accesses stay off the VPU bus
  always_comb begin
    bus.vpu_cs   = 1'b0;
    bus.vpu_rw   = 1'b1;
    bus.vpu_ad   = '0;
    bus.vpu_do   = '0;
    bus.cpu_wait = 1'b0;
    bus.cpu_do   = '0;
    if (!rst) begin
      if (wr_act) begin
        bus.vpu_cs = 1'b1;
        bus.vpu_rw = 1'b0;
        bus.vpu_ad = wr_ad;
        bus.vpu_do = wr_data;
      end else if (grant) begin
        bus.vpu_cs = pt_req;
        bus.vpu_rw = bus.cpu_rw;
        bus.vpu_ad = bus.cpu_ad[3:0];
        bus.vpu_do = bus.cpu_di;
      end
      bus.cpu_wait = pt_req & ~grant;
    end
    if (bus.cpu_ad[4])
      bus.cpu_do = loc_rd;
    else if (grant)
      bus.cpu_do = bus.vpu_di;
  end

endmodule

// File: doc/vpu_line_sched.md
VPU_LINE_SCHED -- requirements
Module: vpu_line_sched

Interface
REQ-001 SHALL have parameter HOLD_TIMEOUT, default 3: max cycles waited for vpu_hold rise after LEN write.
REQ-002 SHALL have these ports, listed as name  direction  width  meaning:
- clk  in  1  single system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hsync  in  1  VPU horizontal sync level.
- vbl  in  1  VPU vertical blanking level.
- cpu_cs  in  1  CPU select.
- cpu_rw  in  1  1=read, 0=write.
- cpu_ad  in  5  bit4=1 local regs, bit4=0 passthrough to VPU reg ad[3:0].
- cpu_di  in  8  CPU write data.
- cpu_do  out  8  CPU read data.
- cpu_wait  out  1  CPU must hold its request.
- vpu_cs  out  1  VPU select.
- vpu_rw  out  1  VPU read/write.
- vpu_ad  out  4  VPU register address.
- vpu_do  out  8  data to VPU DI.
- vpu_di  in  8  data from VPU DO.
- vpu_hold  in  1  VPU DMA active.
- busy  out  1  state != IDLE or pending set.

Function
REQ-003 SHALL provide local regs at cpu_ad[4]=1, ad[2:0]:
- 0: BASEH.
- 1: BASEL.
- 2: STRIDE.
- 3: LEN.
- 4: CTRL (bit0 EN rw, bit7 busy ro, other bits read 0).
- 5-7: read 0, writes ignored.
REQ-004 Local reads SHALL be combinational on cpu_do; local writes SHALL take effect at the next clk edge; local accesses SHALL never assert cpu_wait.
REQ-005 Passthrough is granted when state==IDLE, pending==0 and vpu_hold==0. While granted: vpu_cs=cpu_cs, vpu_rw=cpu_rw, vpu_ad=cpu_ad[3:0], vpu_do=cpu_di, cpu_do=vpu_di, all combinational.
REQ-006 A passthrough request that is not granted SHALL assert cpu_wait combinationally and SHALL drive vpu_cs=0.
REQ-007 SHALL register hsync and vbl once, setting pending on a hsync rising edge while EN=1 and vbl=0.
REQ-008 A vbl rising edge SHALL load line_addr[15:0] from {BASEH,BASEL}.
REQ-009 FSM states, one cycle each unless noted; vpu_rw=0 and vpu_cs=1 in each write state:
- IDLE.
- W_PTRH: AD=0x0, data 0x00.
- W_PTRL: AD=0x1, data 0x00.
- W_ADRH: AD=0xC, data line_addr[15:8].
- W_ADRL: AD=0xD, data line_addr[7:0].
- W_STEP: AD=0xE, data 0x01.
- W_LEN: AD=0xF, data LEN.
- WAIT_RISE.
- WAIT_FALL.
- ADV.
REQ-010 IDLE->W_PTRH when pending=1, clearing pending; otherwise the write states advance in the order of REQ-009.
REQ-011 W_LEN->WAIT_RISE if LEN!=0, else W_LEN->ADV.
REQ-012 WAIT_RISE->WAIT_FALL on vpu_hold=1; WAIT_RISE->ADV after HOLD_TIMEOUT cycles without vpu_hold.
REQ-013 WAIT_FALL SHALL remain until vpu_hold=0, then go to ADV.
REQ-014 ADV SHALL set line_addr <= line_addr + STRIDE, 16-bit wrap, STRIDE zero-extended, then go to IDLE.
REQ-015 A hsync edge arriving while state!=IDLE or pending=1 SHALL be dropped (pending is a single bit, no queue).
REQ-016 A vbl rise coinciding with ADV: the reload SHALL win.
REQ-017 Clearing EN mid-sequence SHALL let the current sequence complete; EN only gates new pending sets.
REQ-018 BASE writes SHALL take effect at the next vbl rise only; STRIDE/LEN writes SHALL be used at the next state that reads them.
REQ-019 A passthrough access in the same cycle as a detected hsync edge SHALL complete, since pending is still 0 that cycle.

Reset
REQ-020 On rst SHALL asynchronously set:
- state=IDLE, pending=0.
- line_addr=0x0000, BASEH=BASEL=0x00.
- STRIDE=0x28, LEN=0x28, EN=0.
- hsync/vbl delay flops=0.
REQ-021 During reset outputs SHALL be: vpu_cs=0, vpu_rw=1, vpu_ad=0, vpu_do=0, cpu_wait=0, busy=0.

Verification
REQ-022 Write BASE=0x4000, EN=1, vbl pulse, hsync rise -> VPU writes 0x0=00, 0x1=00, 0xC=40, 0xD=00, 0xE=01, 0xF=28 on consecutive cycles.
REQ-023 vpu_hold high 5 cycles after LEN write; next hsync -> ADRH/ADRL=0x40/0x28; busy drops one cycle after ADV.
REQ-024 Passthrough read AD=0x08 while in WAIT_FALL -> cpu_wait=1, vpu_cs=0; after hold falls and ADV, read passes through and cpu_do=vpu_di.
REQ-025 LEN=0 -> sequence goes W_LEN->ADV with no waits; vpu_hold never high -> ADV after 3 WAIT_RISE cycles.
REQ-026 BASE=0xFFF0, STRIDE=0x20, two lines -> second ADRH/ADRL=0x00/0x10 (wrap); hsync during vbl=1 or EN=0 -> no VPU writes.
REQ-027 Assert rst during W_ADRH -> vpu_cs=0 immediately, all registers at reset values, next hsync ignored until EN is set again.
